// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus.
// One transaction in flight; grant held from request acceptance until data_ok.
module sram_like_arbiter #(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // slave port
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner;   // 0 = inst, 1 = data
  logic   r_last;
  logic   r_busy;

  logic w_idle;
  logic w_sel;
  logic w_sel_req;
  logic w_req;
  logic w_accept;
  logic w_beat;

  assign w_idle = (r_state == ST_IDLE);

  always_comb begin
    // NOTE: default first so every path assigns w_sel and no latch is inferred.
    w_sel = r_owner;
    if (w_idle) begin
      if (inst_req && data_req) begin
        w_sel = (DATA_PRIORITY != 0) ? 1'b1 : ~r_last;
      end else begin
        w_sel = data_req;
      end
    end
  end

  assign w_sel_req = w_sel ? data_req : inst_req;
  assign w_req     = rst & (r_state != ST_DATA) & w_sel_req;
  assign w_accept  = w_req & addr_ok;
  // A beat in IDLE is only real when its address is accepted in the same cycle.
  assign w_beat    = rst & data_ok & (w_idle ? w_accept : 1'b1);

  assign req   = w_req;
  assign wr    = rst & (w_sel ? data_wr : inst_wr);
  assign size  = {2{rst}}  & (w_sel ? data_size  : inst_size);
  assign addr  = {32{rst}} & (w_sel ? data_addr  : inst_addr);
  assign wdata = {32{rst}} & (w_sel ? data_wdata : inst_wdata);

  assign inst_addr_ok = w_accept & ~w_sel;
  assign data_addr_ok = w_accept &  w_sel;
  assign inst_data_ok = w_beat   & ~w_sel;
  assign data_data_ok = w_beat   &  w_sel;
  assign inst_rdata   = {32{rst}} & rdata;
  assign data_rdata   = {32{rst}} & rdata;

  assign busy = r_busy;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_req) begin
            if (!addr_ok) begin
              r_owner <= w_sel;
              r_state <= ST_ADDR;
              r_busy  <= 1'b1;
            end else if (!data_ok) begin
              r_owner <= w_sel;
              r_state <= ST_DATA;
              r_busy  <= 1'b1;
            end else begin
              r_last  <= w_sel;
            end
          end
        end
        ST_ADDR: begin
          // Owner withdrawing its request before addr_ok abandons the transaction.
          if (!w_sel_req) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (addr_ok) begin
            if (data_ok) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_last  <= r_owner;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (data_ok) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: cycle-by-cycle vector table on a data-priority
// instance, a round-robin sequence on a second instance, and a data_ok scoreboard.
module tb_sram_like_arbiter;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  localparam logic [31:0] IW = 32'h1111_2222;
  localparam logic [31:0] DW = 32'h0BAD_F00D;

  logic        clk, rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, rdata;
  logic        addr_ok, data_ok, rr_addr_ok, rr_data_ok;

  // priority instance outputs
  logic        p_iao, p_ido, p_dao, p_ddo, p_req, p_wr, p_busy;
  logic [1:0]  p_size;
  logic [31:0] p_irdata, p_drdata, p_addr, p_wdata;
  // round-robin instance outputs
  logic        q_iao, q_ido, q_dao, q_ddo, q_req, q_wr, q_busy;
  logic [1:0]  q_size;
  logic [31:0] q_irdata, q_drdata, q_addr, q_wdata;

  sram_like_arbiter #(.DATA_PRIORITY(1)) dut_p (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(p_iao), .inst_data_ok(p_ido), .inst_rdata(p_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(p_dao), .data_data_ok(p_ddo), .data_rdata(p_drdata),
    .req(p_req), .wr(p_wr), .size(p_size), .addr(p_addr), .wdata(p_wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(p_busy)
  );

  sram_like_arbiter #(.DATA_PRIORITY(0)) dut_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(q_iao), .inst_data_ok(q_ido), .inst_rdata(q_irdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(q_dao), .data_data_ok(q_ddo), .data_rdata(q_drdata),
    .req(q_req), .wr(q_wr), .size(q_size), .addr(q_addr), .wdata(q_wdata),
    .addr_ok(rr_addr_ok), .data_ok(rr_data_ok), .rdata(rdata), .busy(q_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected beats {port (1 = data), rdata}
  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } sb_t;

  sb_t sb_p[$];
  sb_t sb_r[$];
  sb_t mon_p, mon_r;

  always @(negedge clk) begin
    if (p_ido || p_ddo) begin
      n_checks++;
      if (sb_p.size() == 0) begin
        n_errors++;
        $display("FAIL sb_p_unexpected: got inst_data_ok=%b data_data_ok=%b expected no beat", p_ido, p_ddo);
      end else begin
        mon_p = sb_p.pop_front();
        if ({p_ido, p_ddo, (p_ddo ? p_drdata : p_irdata)} !== {~mon_p.port, mon_p.port, mon_p.rdata}) begin
          n_errors++;
          $display("FAIL sb_p_beat: got i=%b d=%b rdata=%h expected i=%b d=%b rdata=%h",
                   p_ido, p_ddo, (p_ddo ? p_drdata : p_irdata), ~mon_p.port, mon_p.port, mon_p.rdata);
        end
      end
    end
    if (q_ido || q_ddo) begin
      n_checks++;
      if (sb_r.size() == 0) begin
        n_errors++;
        $display("FAIL sb_r_unexpected: got inst_data_ok=%b data_data_ok=%b expected no beat", q_ido, q_ddo);
      end else begin
        mon_r = sb_r.pop_front();
        if ({q_ido, q_ddo, (q_ddo ? q_drdata : q_irdata)} !== {~mon_r.port, mon_r.port, mon_r.rdata}) begin
          n_errors++;
          $display("FAIL sb_r_beat: got i=%b d=%b rdata=%h expected i=%b d=%b rdata=%h",
                   q_ido, q_ddo, (q_ddo ? q_drdata : q_irdata), ~mon_r.port, mon_r.port, mon_r.rdata);
        end
      end
    end
  end

  typedef struct {
    logic        rst, ireq, iwr, dreq, dwr, aok, dok;
    logic [31:0] iaddr, daddr, dwdata, rd;
    logic        e_req, e_wr, e_iao, e_ido, e_dao, e_ddo, e_busy;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  vec_t vecs[$];

  // ib = {rst, ireq, iwr, dreq, dwr, aok, dok}; eb = {req, wr, iao, ido, dao, ddo, busy}
  function automatic vec_t mk(input logic [6:0] ib, input logic [31:0] da_w, input logic [31:0] rd,
                              input logic [6:0] eb, input logic [31:0] ea, input logic [31:0] ew);
    vec_t v;
    {v.rst, v.ireq, v.iwr, v.dreq, v.dwr, v.aok, v.dok} = ib;
    v.iaddr  = IA;
    v.daddr  = DA;
    v.dwdata = da_w;
    v.rd     = rd;
    {v.e_req, v.e_wr, v.e_iao, v.e_ido, v.e_dao, v.e_ddo, v.e_busy} = eb;
    v.e_addr  = ea;
    v.e_wdata = ew;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst        = v.rst;
    inst_req   = v.ireq;
    inst_wr    = v.iwr;
    data_req   = v.dreq;
    data_wr    = v.dwr;
    addr_ok    = v.aok;
    data_ok    = v.dok;
    inst_addr  = v.iaddr;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    rdata      = v.rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] e_size;
  logic       exp_d;

  initial begin
    rst = 1'b0; inst_req = 1'b0; inst_wr = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    inst_size = 2'd2; data_size = 2'd1; inst_addr = IA; data_addr = DA;
    inst_wdata = IW; data_wdata = DW; rdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rr_addr_ok = 1'b0; rr_data_ok = 1'b0;

    // single inst read, reset forcing, spurious data_ok
    vecs.push_back(mk(7'b0100010, DW, 32'h0,         7'b0000000, 32'h0, 32'h0));
    vecs.push_back(mk(7'b1100010, DW, 32'h0,         7'b1010000, IA, IW));
    vecs.push_back(mk(7'b1000000, DW, 32'h0,         7'b0000001, IA, IW));
    vecs.push_back(mk(7'b1000001, DW, 32'h3C08_0001, 7'b0001001, IA, IW));
    vecs.push_back(mk(7'b1000001, DW, 32'h0000_0055, 7'b0000000, IA, IW));
    // simultaneous requests, data priority
    vecs.push_back(mk(7'b1101010, DW, 32'h0,         7'b1000100, DA, DW));
    vecs.push_back(mk(7'b1101001, DW, 32'h2222_0002, 7'b0000011, DA, DW));
    vecs.push_back(mk(7'b1100010, DW, 32'h0,         7'b1010000, IA, IW));
    vecs.push_back(mk(7'b1000001, DW, 32'h3333_0003, 7'b0001001, IA, IW));
    vecs.push_back(mk(7'b1101010, DW, 32'h0,         7'b1000100, DA, DW));
    vecs.push_back(mk(7'b1000001, DW, 32'h4444_0004, 7'b0000011, DA, DW));
    vecs.push_back(mk(7'b1101000, DW, 32'h0,         7'b1000000, DA, DW));
    vecs.push_back(mk(7'b1101011, DW, 32'h5555_0005, 7'b1000111, DA, DW));
    // grant stability with delayed addr_ok, then owner dropping req in ADDR
    vecs.push_back(mk(7'b1100000, DW, 32'h0,         7'b1000000, IA, IW));
    vecs.push_back(mk(7'b1101000, DW, 32'h0,         7'b1000001, IA, IW));
    vecs.push_back(mk(7'b1101000, DW, 32'h0,         7'b1000001, IA, IW));
    vecs.push_back(mk(7'b1101010, DW, 32'h0,         7'b1010001, IA, IW));
    vecs.push_back(mk(7'b1001000, DW, 32'h0,         7'b0000001, IA, IW));
    vecs.push_back(mk(7'b1001001, DW, 32'h6666_0006, 7'b0001001, IA, IW));
    vecs.push_back(mk(7'b1001000, DW, 32'h0,         7'b1000000, DA, DW));
    vecs.push_back(mk(7'b1000000, DW, 32'h0,         7'b0000001, DA, DW));
    vecs.push_back(mk(7'b1000001, DW, 32'h0000_0066, 7'b0000000, IA, IW));
    // same-cycle addr_ok+data_ok write, pending inst forwarded next cycle
    vecs.push_back(mk(7'b1101111, 32'hDEAD_BEEF, 32'h7777_0007, 7'b1100110, DA, 32'hDEAD_BEEF));
    vecs.push_back(mk(7'b1100000, DW, 32'h0,         7'b1000000, IA, IW));
    vecs.push_back(mk(7'b1100011, DW, 32'h8888_0008, 7'b1011001, IA, IW));
    // reset in DATA, late data_ok, then a normal transaction
    vecs.push_back(mk(7'b1001010, DW, 32'h0,         7'b1000100, DA, DW));
    vecs.push_back(mk(7'b0001000, DW, 32'h0,         7'b0000000, 32'h0, 32'h0));
    vecs.push_back(mk(7'b1000001, DW, 32'h0000_0077, 7'b0000000, IA, IW));
    vecs.push_back(mk(7'b1100011, DW, 32'h9999_0009, 7'b1011000, IA, IW));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      if (vecs[i].e_ido || vecs[i].e_ddo) sb_p.push_back({vecs[i].e_ddo, vecs[i].rd});
      e_size = (vecs[i].e_addr == DA) ? 2'd1 : ((vecs[i].e_addr == IA) ? 2'd2 : 2'd0);
      @(negedge clk);
      check($sformatf("row%0d_req",   i), {31'b0, p_req},  {31'b0, vecs[i].e_req});
      check($sformatf("row%0d_wr",    i), {31'b0, p_wr},   {31'b0, vecs[i].e_wr});
      check($sformatf("row%0d_iao",   i), {31'b0, p_iao},  {31'b0, vecs[i].e_iao});
      check($sformatf("row%0d_ido",   i), {31'b0, p_ido},  {31'b0, vecs[i].e_ido});
      check($sformatf("row%0d_dao",   i), {31'b0, p_dao},  {31'b0, vecs[i].e_dao});
      check($sformatf("row%0d_ddo",   i), {31'b0, p_ddo},  {31'b0, vecs[i].e_ddo});
      check($sformatf("row%0d_busy",  i), {31'b0, p_busy}, {31'b0, vecs[i].e_busy});
      check($sformatf("row%0d_addr",  i), p_addr,  vecs[i].e_addr);
      check($sformatf("row%0d_wdata", i), p_wdata, vecs[i].e_wdata);
      check($sformatf("row%0d_size",  i), {30'b0, p_size}, {30'b0, e_size});
      @(posedge clk);
      #1;
    end

    // Round-robin instance: both requests held, grants alternate starting with data
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    data_wdata = DW; rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d      = (k % 2 == 0);
      inst_req   = 1'b1;
      data_req   = 1'b1;
      rr_addr_ok = 1'b1;
      rr_data_ok = 1'b0;
      @(negedge clk);
      check($sformatf("rr%0d_dao", k),  {31'b0, q_dao},  {31'b0, exp_d});
      check($sformatf("rr%0d_iao", k),  {31'b0, q_iao},  {31'b0, ~exp_d});
      check($sformatf("rr%0d_addr", k), q_addr, exp_d ? DA : IA);
      check($sformatf("rr%0d_busy_idle", k), {31'b0, q_busy}, 32'd0);
      @(posedge clk);
      #1;
      rr_addr_ok = 1'b0;
      rr_data_ok = 1'b1;
      rdata      = 32'hA000_0000 + 32'(k);
      sb_r.push_back({exp_d, rdata});
      @(negedge clk);
      check($sformatf("rr%0d_busy_data", k), {31'b0, q_busy}, 32'd1);
      check($sformatf("rr%0d_req_data", k),  {31'b0, q_req},  32'd0);
      @(posedge clk);
      #1;
    end
    rr_data_ok = 1'b0;
    inst_req   = 1'b0;
    data_req   = 1'b0;
    @(negedge clk);

    check("sb_p_drained", 32'(sb_p.size()), 32'd0);
    check("sb_r_drained", 32'(sb_r.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master, one-slave arbiter for the SoC's sram-like bus. It sits between the instruction-side and data-side sram-like bridges and the single sram-like port of the AXI interface, multiplexing one transaction at a time. Grant is held from request acceptance to read/write completion, so a requester never sees another requester's `data_ok` or its own request dropped mid-handshake.

## Interface
- `DATA_PRIORITY`, default 1: 1 = data port always wins a simultaneous request; 0 = round-robin between the two ports.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; while low, the FSM is held in IDLE and every output is forced to 0.
- `inst_req, inst_wr`  in  1  instruction master request and write flag.
- `inst_size`  in  2  instruction transfer size.
- `inst_addr, inst_wdata`  in  32  instruction address and write data.
- `inst_addr_ok, inst_data_ok`  out  1  address and data handshakes back to the instruction master.
- `inst_rdata`  out  32  read data to the instruction master.
- `data_req, data_wr, data_size, data_addr, data_wdata`  in  1/1/2/32/32  data master request fields, same meaning as the `inst_*` fields.
- `data_addr_ok, data_data_ok, data_rdata`  out  1/1/32  handshakes and read data back to the data master.
- `req, wr`  out  1  request and write flag to the slave.
- `size`  out  2  transfer size to the slave.
- `addr, wdata`  out  32  address and write data to the slave.
- `addr_ok, data_ok`  in  1  slave handshakes.
- `rdata`  in  32  slave read data.
- `busy`  out  1  high in ADDR or DATA.

## Operation
FSM states:
- IDLE: no transaction is owned.
- ADDR: grant is latched and the arbiter waits for `addr_ok`.
- DATA: address has been accepted and the arbiter waits for `data_ok`.

Registers:
- `state` (reset: IDLE).
- `owner` (0 = inst, 1 = data; reset: 0).
- `last` (last granted port; reset: inst, so data wins the first tie in either mode).

Selection `sel` in IDLE:
- Only one port requesting: that port.
- Both requesting, `DATA_PRIORITY`=1: data.
- Both requesting, `DATA_PRIORITY`=0: the port ≠ `last`.
- In ADDR or DATA: `sel` = `owner`.

Slave-side outputs:
- `req` = request of `sel` in IDLE or ADDR; 0 in DATA.
- `wr`, `size`, `addr`, `wdata` come from `sel`; they are don't-care when `req`=0 but are still driven by `sel`.

Return path:
- `x_addr_ok` = `addr_ok` & `req` & (`sel`==x).
- `x_data_ok` = `data_ok` & (`sel`==x) & (state≠IDLE, or a same-cycle accept in IDLE).
- `inst_rdata` = `data_rdata` = `rdata` (broadcast; qualified only by `x_data_ok`).

Transitions:
- IDLE, any req, `addr_ok`=0: latch `owner`←`sel`, go to ADDR.
- IDLE, any req, `addr_ok`=1, `data_ok`=0: latch `owner`, go to DATA.
- IDLE, any req, `addr_ok`=1, `data_ok`=1: remain in IDLE; `last`←`sel`.
- ADDR, `addr_ok`=1: go to DATA, or to IDLE if `data_ok` arrives in the same cycle.
- ADDR, owner's req drops before `addr_ok`: go to IDLE with no beat forwarded (protocol violation; tolerated, not flagged).
- DATA, `data_ok`=1: go to IDLE; `last`←`owner`.
- The other port's request is ignored for the whole of ADDR and DATA.

Boundary rules:
- `data_ok` while in IDLE with no accepted address: spurious; dropped, and neither `x_data_ok` asserts.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. Any late `data_ok` after reset release is spurious and dropped per the rule above.

## Timing
- Zero-cycle forwarding: a request in IDLE appears on `req` in the same cycle. `addr_ok` and `data_ok` pass through combinationally.
- Minimum transaction: 1 cycle (`addr_ok` and `data_ok` in the cycle of the request). Back-to-back transactions are possible on consecutive cycles.
- Only one transaction is outstanding at any time.
- A new grant is never issued in the cycle DATA exits; the next grant is issued in the following cycle (IDLE).
- Outputs while `rst`=0: `req`=0, `inst_addr_ok`=`data_addr_ok`=`inst_data_ok`=`data_data_ok`=0, `busy`=0.

## Test plan
- Single inst read: `inst_req`=1, `addr`=0xBFC00000; slave gives `addr_ok` at cycle 0 and `data_ok`+`rdata`=0x3C080001 at cycle 2 → `inst_addr_ok` at cycle 0, `inst_data_ok` with 0x3C080001 at cycle 2, `busy` high during cycles 1–2, `data_data_ok` never asserts.
- Simultaneous requests, `DATA_PRIORITY`=1: both reqs held, slave latency 1 → data transaction completes first, then inst; repeating the test → data wins again.
- Simultaneous requests, `DATA_PRIORITY`=0, held continuously → grants alternate data, inst, data, inst.
- Grant stability: inst granted in ADDR with `addr_ok` delayed 3 cycles while `data_req` rises at cycle 1 → `addr` stays the inst address, and `data_addr_ok` stays 0 until inst's `data_ok`.
- Same-cycle `addr_ok`&`data_ok` on data write (`wr`=1, `wdata`=0xDEADBEEF) → FSM stays IDLE and a pending inst req is forwarded on the next cycle.
- Reset asserted in DATA, then a late `data_ok` after release → no `x_data_ok` pulse, `req`=0 during reset, and a normal transaction follows.
